// File: rtl/pll_lock_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the system reset; re-resets the PLL on lock loss and faults after repeated timeouts.
module pll_lock_rst_ctrl #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int LOSS_FILTER    = 4,
   parameter int MAX_RETRIES    = 7,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lock,
   output logic       pll_reset,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fault,
   output logic [2:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);
   localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRIES);

   state_t           state, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       retry_nxt;
   logic [7:0]       loss_nxt;
   logic             sync1, lock_s;

   always_comb begin
      nxt       = state;
      cnt_nxt   = cnt + CNT_W'(1);
      retry_nxt = retry_cnt;
      loss_nxt  = loss_cnt;
      case (state)
         RESET_PLL: if (cnt == RST_LAST) nxt = WAIT_LOCK;
         WAIT_LOCK: begin
            // lock wins over a timeout landing on the same cycle
            if (lock_s) nxt = STABLE;
            else if (cnt == TIMEOUT_LAST) begin
               if (retry_cnt == RETRY_MAX) nxt = FAULT;
               else begin
                  retry_nxt = retry_cnt + 3'd1;
                  nxt       = RESET_PLL;
               end
            end
         end
         STABLE: begin
            if (!lock_s) nxt = WAIT_LOCK;
            else if (cnt == STABLE_LAST) nxt = RUN;
         end
         RUN: begin
            // counter tracks the current run of consecutive low lock samples
            if (lock_s) cnt_nxt = '0;
            else if (cnt == LOSS_LAST) begin
               nxt = RESET_PLL;
               if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 8'd1;
            end
         end
         FAULT:   cnt_nxt = cnt;
         default: nxt = RESET_PLL;
      endcase
      if (nxt != state) cnt_nxt = '0;
      if (nxt == RUN && state != RUN) retry_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 1'b0;
         lock_s    <= 1'b0;
         state     <= RESET_PLL;
         cnt       <= '0;
         pll_reset <= 1'b1;
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
         fault     <= 1'b0;
         retry_cnt <= '0;
         loss_cnt  <= '0;
      end else begin
         sync1     <= lock;
         lock_s    <= sync1;
         state     <= nxt;
         cnt       <= cnt_nxt;
         pll_reset <= (nxt == RESET_PLL) || (nxt == FAULT);
         sys_rst_n <= (nxt == RUN);
         ready     <= (nxt == RUN);
         fault     <= (nxt == FAULT);
         retry_cnt <= retry_nxt;
         loss_cnt  <= loss_nxt;
      end
   end

endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
// Directed bench for pll_lock_rst_ctrl: a vector table for bring-up and loss filtering,
// plus hand sequences for async reset, STABLE glitch, timeout/fault and saturation.
module tb_pll_lock_rst_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lock;
   logic       pll_reset, sys_rst_n, ready, fault;
   logic [2:0] retry_cnt;
   logic [7:0] loss_cnt;

   int n_pass  = 0;
   int n_total = 0;

   pll_lock_rst_ctrl #(
      .PLL_RST_CYCLES(4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8),
      .LOSS_FILTER   (3),
      .MAX_RETRIES   (2),
      .CNT_W         (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lock      (lock),
      .pll_reset (pll_reset),
      .sys_rst_n (sys_rst_n),
      .ready     (ready),
      .fault     (fault),
      .retry_cnt (retry_cnt),
      .loss_cnt  (loss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rst_n;
      bit lock;
      int cyc;
      int pll, srst, rdy, flt, rc, lc;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // {rst_n, lock, cycles, pll_reset, sys_rst_n, ready, fault, retry_cnt, loss_cnt}
      vecs[0]  = '{1'b0, 1'b0, 2,  1, 0, 0, 0, 0, 0}; // reset values
      vecs[1]  = '{1'b1, 1'b0, 3,  1, 0, 0, 0, 0, 0}; // pll_reset still high after 3 edges
      vecs[2]  = '{1'b1, 1'b0, 1,  0, 0, 0, 0, 0, 0}; // drops on 4th edge
      vecs[3]  = '{1'b1, 1'b0, 6,  0, 0, 0, 0, 0, 0}; // 10 cycles after release
      vecs[4]  = '{1'b1, 1'b1, 10, 0, 0, 0, 0, 0, 0}; // 10 edges after lock rise
      vecs[5]  = '{1'b1, 1'b1, 1,  0, 1, 1, 0, 0, 0}; // released on 11th edge
      vecs[6]  = '{1'b1, 1'b0, 2,  0, 1, 1, 0, 0, 0}; // 2-cycle low pulse
      vecs[7]  = '{1'b1, 1'b1, 4,  0, 1, 1, 0, 0, 0}; // ignored
      vecs[8]  = '{1'b1, 1'b0, 4,  0, 1, 1, 0, 0, 0}; // sustained low: 4 edges, still RUN
      vecs[9]  = '{1'b1, 1'b0, 1,  1, 0, 0, 0, 0, 1}; // 5th edge: loss
      vecs[10] = '{1'b1, 1'b0, 3,  1, 0, 0, 0, 0, 1}; // pll_reset pulse continues
      vecs[11] = '{1'b1, 1'b0, 1,  0, 0, 0, 0, 0, 1}; // ends after 4 cycles
      vecs[12] = '{1'b1, 1'b1, 10, 0, 0, 0, 0, 0, 1};
      vecs[13] = '{1'b1, 1'b1, 1,  0, 1, 1, 0, 0, 1}; // re-released

      rst_n = 1'b0;
      lock  = 1'b0;
      step(1);
      for (int i = 0; i < 14; i++) begin
         rst_n = vecs[i].rst_n;
         lock  = vecs[i].lock;
         step(vecs[i].cyc);
         chk($sformatf("vec%0d.pll_reset", i), int'(pll_reset), vecs[i].pll);
         chk($sformatf("vec%0d.sys_rst_n", i), int'(sys_rst_n), vecs[i].srst);
         chk($sformatf("vec%0d.ready", i),     int'(ready),     vecs[i].rdy);
         chk($sformatf("vec%0d.fault", i),     int'(fault),     vecs[i].flt);
         chk($sformatf("vec%0d.retry_cnt", i), int'(retry_cnt), vecs[i].rc);
         chk($sformatf("vec%0d.loss_cnt", i),  int'(loss_cnt),  vecs[i].lc);
      end

      // async reset between edges while in RUN
      #2 rst_n = 1'b0;
      #1;
      chk("async.sys_rst_n", int'(sys_rst_n), 0);
      chk("async.pll_reset", int'(pll_reset), 1);
      chk("async.ready",     int'(ready),     0);
      chk("async.loss_cnt",  int'(loss_cnt),  0);
      @(negedge clk);
      lock = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(3);
      chk("rebring.pll_hi", int'(pll_reset), 1);
      step(1);
      chk("rebring.pll_lo", int'(pll_reset), 0);
      step(6);
      lock = 1'b1;
      step(7);
      chk("glitch.pre_sys", int'(sys_rst_n), 0);
      // one-cycle drop four cycles into STABLE
      lock = 1'b0;
      step(1);
      lock = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         step(1);
         chk($sformatf("glitch.sys_k%0d", k), int'(sys_rst_n), (k == 11) ? 1 : 0);
         chk($sformatf("glitch.pll_k%0d", k), int'(pll_reset), 0);
      end
      chk("glitch.retry_cnt", int'(retry_cnt), 0);

      // lock never arrives: two retries then FAULT
      rst_n = 1'b0;
      lock  = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(23);
      chk("to1.pll_pre",  int'(pll_reset), 0);
      chk("to1.retry_pre", int'(retry_cnt), 0);
      step(1);
      chk("to1.pll",   int'(pll_reset), 1);
      chk("to1.retry", int'(retry_cnt), 1);
      step(23);
      chk("to2.pll_pre", int'(pll_reset), 0);
      step(1);
      chk("to2.pll",   int'(pll_reset), 1);
      chk("to2.retry", int'(retry_cnt), 2);
      step(23);
      chk("to3.pll_pre",   int'(pll_reset), 0);
      chk("to3.fault_pre", int'(fault),     0);
      step(1);
      chk("fault.fault", int'(fault),     1);
      chk("fault.pll",   int'(pll_reset), 1);
      chk("fault.sys",   int'(sys_rst_n), 0);
      chk("fault.ready", int'(ready),     0);
      for (int k = 0; k < 20; k++) begin
         lock = ~lock;
         step(1);
      end
      lock = 1'b1;
      step(20);
      chk("fault.sticky",     int'(fault),     1);
      chk("fault.sticky_pll", int'(pll_reset), 1);
      chk("fault.sticky_sys", int'(sys_rst_n), 0);

      // 260 lock-loss events: counter saturates
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(20);
      chk("sat.ready_start", int'(ready),    1);
      chk("sat.loss_start",  int'(loss_cnt), 0);
      for (int i = 0; i < 260; i++) begin
         lock = 1'b0;
         step(6);
         lock = 1'b1;
         step(15);
         if (i == 0)   chk("sat.loss_first", int'(loss_cnt), 1);
         if (i == 254) chk("sat.loss_255",   int'(loss_cnt), 255);
      end
      chk("sat.loss_final",  int'(loss_cnt), 255);
      chk("sat.ready_final", int'(ready),    1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
